// File: rtl/data_capture.sv
// data_capture: receive end of the filter output stream.
//   Captures valid-qualified samples into a circular buffer, keeps a running
//   checksum of every sample seen, and raises DONE once the expected number of
//   samples has arrived or the stream has gone idle after it started.
//   The buffer can still be drained after DONE.
// Ports:
//   CLK, RST_N         clock (rising edge), asynchronous active-low reset
//   VIN, DIN           sample valid and sample (two's complement, NB bits)
//   RD_EN              drain request, one sample per cycle
//   RD_DATA, RD_VALID  drained sample, valid one cycle after an accepted RD_EN
//   COUNT, FULL, EMPTY buffer occupancy and its two decoded limits
//   OVERFLOW           sticky: a sample was dropped because the buffer was full
//   CHECKSUM           wrapping sum of sign-extended DIN over every counted sample
//   DONE, TIMED_OUT    sticky completion flag and its cause
module data_capture #(
  parameter int NB      = 10,
  parameter int DEPTH   = 16,
  parameter int NSAMP   = 64,
  parameter int TIMEOUT = 32,
  parameter int CSW     = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     VIN,
  input  logic [NB-1:0]            DIN,
  input  logic                     RD_EN,
  output logic [NB-1:0]            RD_DATA,
  output logic                     RD_VALID,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     OVERFLOW,
  output logic [CSW-1:0]           CHECKSUM,
  output logic                     DONE,
  output logic                     TIMED_OUT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(NSAMP + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] DEPTH_V    = CW'(DEPTH);
  localparam logic [TW-1:0] NSAMP_M1   = TW'(NSAMP - 1);
  localparam logic [IW-1:0] TIMEOUT_M1 = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e          state_q,     state_d;
  logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]   count_q,     count_d;
  logic [NB-1:0]   rd_data_q,   rd_data_d;
  logic            rd_valid_q,  rd_valid_d;
  logic            overflow_q,  overflow_d;
  logic [CSW-1:0]  checksum_q,  checksum_d;
  logic            done_q,      done_d;
  logic            timed_out_q, timed_out_d;
  logic [TW-1:0]   total_q,     total_d;
  logic [IW-1:0]   idle_q,      idle_d;

  logic [NB-1:0]   mem_q [DEPTH];

  logic            full, empty, accept, rd_ok, wr_en;
  logic [CSW-1:0]  din_ext;

  assign full    = (count_q == DEPTH_V);
  assign empty   = (count_q == '0);
  assign din_ext = CSW'($signed(DIN));

  // Every sample outside DONE is counted; storing it additionally needs a free
  // slot, which a same-cycle read provides even when the buffer is full.
  assign accept  = VIN && (state_q != ST_DONE);
  assign rd_ok   = RD_EN && !empty;
  assign wr_en   = accept && (!full || rd_ok);

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_ok;
    overflow_d  = overflow_q;
    checksum_d  = checksum_q;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    total_d     = total_q;
    idle_d      = idle_q;

    if (rd_ok) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;

    unique case ({wr_en, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (accept) begin
      if (!wr_en) overflow_d = 1'b1;
      checksum_d = checksum_q + din_ext;
      total_d    = total_q + 1'b1;
    end

    // Sample-count completion is checked before the idle timeout, so the
    // NSAMP-th sample wins any tie.
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (total_q == NSAMP_M1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          idle_d = '0;
          if (total_q == NSAMP_M1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else if (idle_q == TIMEOUT_M1) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      checksum_q  <= '0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      total_q     <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      checksum_q  <= checksum_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      total_q     <= total_d;
      idle_q      <= idle_d;
    end
  end

  // NOTE: the sample storage is deliberately not reset; COUNT gates every read,
  // so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= DIN;
  end

  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign COUNT     = count_q;
  assign FULL      = full;
  assign EMPTY     = empty;
  assign OVERFLOW  = overflow_q;
  assign CHECKSUM  = checksum_q;
  assign DONE      = done_q;
  assign TIMED_OUT = timed_out_q;

endmodule

// File: tb/tb_data_capture.sv
// tb_data_capture: self-checking bench for data_capture.
//   A queue model of the buffer records each stored sample as it is driven;
//   accepted reads move the head into a scoreboard that is popped and compared
//   when RD_VALID appears. Completion, checksum and overflow are modelled too.
module tb_data_capture;

  localparam int NB      = 10;
  localparam int DEPTH   = 16;
  localparam int NSAMP   = 64;
  localparam int TIMEOUT = 32;
  localparam int CSW     = 16;

  logic                   CLK   = 1'b0;
  logic                   RST_N = 1'b0;
  logic                   VIN   = 1'b0;
  logic [NB-1:0]          DIN   = '0;
  logic                   RD_EN = 1'b0;
  logic [NB-1:0]          RD_DATA;
  logic                   RD_VALID;
  logic [$clog2(DEPTH):0] COUNT;
  logic                   FULL, EMPTY, OVERFLOW, DONE, TIMED_OUT;
  logic [CSW-1:0]         CHECKSUM;

  data_capture #(
    .NB(NB), .DEPTH(DEPTH), .NSAMP(NSAMP), .TIMEOUT(TIMEOUT), .CSW(CSW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .VIN(VIN), .DIN(DIN), .RD_EN(RD_EN),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .COUNT(COUNT), .FULL(FULL),
    .EMPTY(EMPTY), .OVERFLOW(OVERFLOW), .CHECKSUM(CHECKSUM), .DONE(DONE),
    .TIMED_OUT(TIMED_OUT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [NB-1:0]  mbuf[$];
  logic [NB-1:0]  rd_exp[$];
  logic [CSW-1:0] m_sum;
  int             m_total;
  int             m_idle;
  bit             m_run, m_done, m_to, m_ovf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbuf.delete();
    rd_exp.delete();
    m_sum   = '0;
    m_total = 0;
    m_idle  = 0;
    m_run   = 0;
    m_done  = 0;
    m_to    = 0;
    m_ovf   = 0;
  endtask

  task automatic do_reset();
    VIN   = 1'b0;
    RD_EN = 1'b0;
    DIN   = '0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus; updates the model, then checks the DUT #1 after the edge.
  task automatic cycle(input bit vin, input int din, input bit rd);
    logic [NB-1:0] d;
    bit rd_acc, acc, wr;
    d      = NB'(din);
    rd_acc = rd && (mbuf.size() > 0);
    acc    = vin && !m_done;
    wr     = acc && ((mbuf.size() < DEPTH) || rd_acc);
    if (rd_acc) rd_exp.push_back(mbuf.pop_front());
    if (wr) mbuf.push_back(d);
    if (acc && !wr) m_ovf = 1;
    if (acc) begin
      m_sum += CSW'(din);
      m_total++;
    end
    if (!m_done) begin
      if (acc) begin
        m_idle = 0;
        if (m_total == NSAMP) m_done = 1;
        else m_run = 1;
      end else if (m_run) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_done = 1;
          m_to   = 1;
        end
      end
    end

    VIN   = vin;
    DIN   = d;
    RD_EN = rd;
    @(posedge CLK);
    #1;
    check("rd_valid", RD_VALID, rd_acc);
    if (RD_VALID && rd_exp.size() > 0) check("rd_data", RD_DATA, rd_exp.pop_front());
    check("count", COUNT, mbuf.size());
    check("checksum", CHECKSUM, m_sum);
    check("overflow", OVERFLOW, m_ovf);
    check("done", DONE, m_done);
    check("timed_out", TIMED_OUT, m_to);
    VIN   = 1'b0;
    RD_EN = 1'b0;
  endtask

  initial begin
    int vals[4];
    int gaps[3];
    vals = '{3, -1, 511, -512};
    gaps = '{0, 1, 2};

    // Reset state.
    do_reset();
    check("rst_rd_data",   RD_DATA,   0);
    check("rst_rd_valid",  RD_VALID,  0);
    check("rst_count",     COUNT,     0);
    check("rst_full",      FULL,      0);
    check("rst_empty",     EMPTY,     1);
    check("rst_overflow",  OVERFLOW,  0);
    check("rst_checksum",  CHECKSUM,  0);
    check("rst_done",      DONE,      0);
    check("rst_timed_out", TIMED_OUT, 0);

    // Ordering with irregular VIN gaps, then a 4-cycle drain.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vals[i], 1'b0);
      if (i < 3) repeat (gaps[i]) cycle(1'b0, 0, 1'b0);
    end
    repeat (4) cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0);
    check("order_empty", EMPTY, 1);

    // Asynchronous reset mid-stream with COUNT=5.
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b1, i, 1'b0);
    check("mid_count5", COUNT, 5);
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_rst_count", COUNT, 0);
    check("mid_rst_done",  DONE,  0);
    check("mid_rst_empty", EMPTY, 1);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();

    // Full and overflow: 1..17 back-to-back, 17 dropped, drain 1..16.
    for (int i = 1; i <= 17; i++) cycle(1'b1, i, 1'b0);
    check("full_flag",     FULL,     1);
    check("full_overflow", OVERFLOW, 1);
    check("full_count",    COUNT,    16);
    check("full_checksum", CHECKSUM, 16'd153);
    repeat (16) cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0);
    check("full_drained", EMPTY, 1);

    // Simultaneous write and read while full; pointers wrap several times.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 100 + i, 1'b0);
    check("sim_full", FULL, 1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 200 + i, 1'b1);
    check("sim_count",    COUNT,    16);
    check("sim_overflow", OVERFLOW, 0);
    repeat (16) cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0);
    check("sim_drained", EMPTY, 1);

    // Completion on count: 64 samples of -2, then a 65th that must be ignored.
    do_reset();
    for (int i = 0; i < NSAMP; i++) begin
      cycle(1'b1, -2, 1'b0);
      check("cnt_done_edge", DONE, i == NSAMP - 1);
    end
    check("cnt_timed_out", TIMED_OUT, 0);
    check("cnt_checksum",  CHECKSUM,  16'hFF80);
    cycle(1'b1, 5, 1'b0);
    check("cnt_65_checksum", CHECKSUM, 16'hFF80);
    check("cnt_65_count",    COUNT,    16);
    check("cnt_65_done",     DONE,     1);

    // Completion on timeout: 10 samples, 32 idle cycles, then drain after DONE.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, i * 50 - 200, 1'b0);
    for (int j = 0; j < TIMEOUT; j++) begin
      cycle(1'b0, 0, 1'b0);
      check("to_done_edge",  DONE,      j == TIMEOUT - 1);
      check("to_timed_edge", TIMED_OUT, j == TIMEOUT - 1);
    end
    repeat (10) cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0);
    check("to_drained", EMPTY, 1);
    check("sb_empty", rd_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
